// File: rtl/ram_arbiter.sv
// Purpose: shares one single-port 32-bit RAM between instruction fetch (I) and load/store (D), D > I with I starvation guard.
// Latency: request sampled in IDLE -> ACCESS next cycle -> one-cycle ack the cycle after; one access every 3 cycles.
// Backpressure: requesters hold req until their ack; requests are only sampled in IDLE, never back-to-back.
module ram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic             owner_i;
    logic             i_ack_q;
    logic             d_ack_q;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_i;
    logic [CNT_W-1:0] starve_nxt;

    // I wins when alone, or when D has already been preferred STARVE_LIMIT times in a row.
    always_comb begin
        grant_i    = i_req && (!d_req || (starve_cnt == CNT_MAX));
        starve_nxt = starve_cnt;
        if (grant_i || !i_req) begin
            starve_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_i    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            busy       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_we  <= 1'b0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    if (i_req || d_req) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        owner_i    <= grant_i;
                        starve_cnt <= starve_nxt;
                        if (grant_i) begin
                            ram_addr <= i_addr;
                            ram_we   <= 1'b0;
                        end else begin
                            ram_addr  <= d_addr;
                            ram_we    <= d_we;
                            ram_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    ram_we  <= 1'b0;
                    state   <= DONE;
                    i_ack_q <= owner_i;
                    d_ack_q <= !owner_i;
                end
                DONE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ram_we  <= 1'b0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A reset landing in DONE aborts the access, so the pending ack is suppressed in that same cycle.
    assign i_ack   = i_ack_q && !reset;
    assign d_ack   = d_ack_q && !reset;
    assign i_rdata = ram_rdata;
    assign d_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomised checks of ram_arbiter against a registered single-port RAM model.
module tb_ram_arbiter;

    localparam int ADDR_W       = 10;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .busy     (busy)
    );

    // Registered single-port RAM: data_out only updates after a non-write cycle.
    logic [31:0] ram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one D access from an IDLE cycle; returns data, ack latency (-1 on timeout), and whether I was acked meanwhile.
    task automatic d_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic saw_i);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        lat = -1; saw_i = 1'b0; rd = 'x;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (i_ack) saw_i = 1'b1;
            if (d_ack) begin
                lat = c;
                rd  = d_rdata;
                break;
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic i_op(input logic [ADDR_W-1:0] addr, output logic [31:0] rd, output int lat,
                        output logic [ADDR_W-1:0] acc_addr);
        i_req = 1'b1; i_addr = addr;
        lat = -1; rd = 'x; acc_addr = 'x;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) acc_addr = ram_addr;
            if (i_ack) begin
                lat = c;
                rd  = i_rdata;
                break;
            end
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) tick();
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (ram_we !== 1'b0)   begin fails++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        tests++; if (ram_addr !== '0)   begin fails++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr); end
        tests++; if (ram_wdata !== '0)  begin fails++; $display("FAIL reset_ram_wdata: got %h expected 0", ram_wdata); end
        tests++; if ({i_ack, d_ack} !== 2'b00) begin fails++; $display("FAIL reset_acks: got %b expected 00", {i_ack, d_ack}); end
        reset = 1'b0;
        repeat (3) tick();
        tests++; if ({busy, ram_we, i_ack, d_ack} !== 4'b0000) begin
            fails++; $display("FAIL idle_no_req: got %b expected 0000", {busy, ram_we, i_ack, d_ack});
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        int          lat;
        logic        saw_i;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h005; d_wdata = 32'hDEADBEEF;
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL store_we_cycle0: got %b expected 0", ram_we); end
        tick();
        tests++; if ({ram_we, busy, d_ack} !== 3'b110) begin
            fails++; $display("FAIL store_access_cycle: got we/busy/ack %b expected 110", {ram_we, busy, d_ack});
        end
        tests++; if ({ram_addr, ram_wdata} !== {10'h005, 32'hDEADBEEF}) begin
            fails++; $display("FAIL store_access_bus: got %h/%h expected 005/deadbeef", ram_addr, ram_wdata);
        end
        tick();
        tests++; if ({ram_we, d_ack, i_ack} !== 3'b010) begin
            fails++; $display("FAIL store_done_cycle: got we/d_ack/i_ack %b expected 010", {ram_we, d_ack, i_ack});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        tests++; if ({busy, d_ack} !== 2'b00) begin
            fails++; $display("FAIL store_back_idle: got busy/ack %b expected 00", {busy, d_ack});
        end
        d_op(1'b0, 10'h005, 32'h0, rd, lat, saw_i);
        tests++; if (lat !== 2) begin fails++; $display("FAIL load_latency: got %0d expected 2", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data: got %h expected deadbeef", rd); end
        tests++; if (saw_i !== 1'b0) begin fails++; $display("FAIL load_no_i_ack: got %b expected 0", saw_i); end
    endtask

    task automatic test_both_same_cycle();
        int          dc = -1;
        int          ic = -1;
        logic [31:0] dr = 'x;
        logic [31:0] ir = 'x;
        logic        both = 1'b0;
        i_req = 1'b1; i_addr = 10'h005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (i_ack && d_ack) both = 1'b1;
            if (d_ack && dc < 0) begin dc = c; dr = d_rdata; d_req = 1'b0; end
            if (i_ack && ic < 0) begin ic = c; ir = i_rdata; i_req = 1'b0; end
        end
        d_req = 1'b0; i_req = 1'b0;
        tests++; if (dc !== 2) begin fails++; $display("FAIL both_d_ack_cycle: got %0d expected 2", dc); end
        tests++; if (ic !== 5) begin fails++; $display("FAIL both_i_ack_cycle: got %0d expected 5", ic); end
        tests++; if (dr !== 32'hDEADBEEF) begin fails++; $display("FAIL both_d_data: got %h expected deadbeef", dr); end
        tests++; if (ir !== 32'hDEADBEEF) begin fails++; $display("FAIL both_i_data: got %h expected deadbeef", ir); end
        tests++; if (both !== 1'b0) begin fails++; $display("FAIL both_acks_together: got %b expected 0", both); end
    endtask

    task automatic test_starvation();
        logic [9:0] seq = '0;
        int         n = 0;
        int         bad_slot = 0;
        i_req = 1'b1; i_addr = 10'h005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (i_ack || d_ack) begin
                if ((c % 3) != 2) bad_slot++;
                if (n < 10) seq[n] = i_ack;
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tests++; if (n !== 10) begin fails++; $display("FAIL starve_ack_count: got %0d expected 10", n); end
        tests++; if (seq !== 10'b10_0001_0000) begin
            fails++; $display("FAIL starve_order: got %b expected 1000010000 (bit0 first, 1=I)", seq);
        end
        tests++; if (bad_slot !== 0) begin fails++; $display("FAIL starve_spacing: got %0d off-slot acks expected 0", bad_slot); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL starve_idle_after: got busy %b expected 0", busy); end
    endtask

    task automatic test_top_address();
        logic [31:0]       rd;
        int                lat;
        logic              saw_i;
        logic [ADDR_W-1:0] acc;
        d_op(1'b1, 10'h3FF, 32'hCAFEF00D, rd, lat, saw_i);
        tests++; if (lat !== 2) begin fails++; $display("FAIL top_store_latency: got %0d expected 2", lat); end
        d_op(1'b1, 10'h000, 32'h0BADF00D, rd, lat, saw_i);
        i_op(10'h3FF, rd, lat, acc);
        tests++; if (lat !== 2) begin fails++; $display("FAIL top_fetch_latency: got %0d expected 2", lat); end
        tests++; if (acc !== 10'h3FF) begin fails++; $display("FAIL top_ram_addr: got %h expected 3ff", acc); end
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL top_fetch_data: got %h expected cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          lat;
        logic        saw_i;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        tick();
        tick();
        tests++; if (d_ack !== 1'b1) begin fails++; $display("FAIL rst_done_pre_ack: got %b expected 1", d_ack); end
        reset = 1'b1; d_req = 1'b0;
        #1;
        tests++; if (d_ack !== 1'b0) begin fails++; $display("FAIL rst_done_ack_suppressed: got %b expected 0", d_ack); end
        tick();
        tests++; if ({busy, ram_we, ram_addr, ram_wdata, i_ack, d_ack} !== '0) begin
            fails++; $display("FAIL rst_done_outputs: got busy=%b we=%b addr=%h wdata=%h acks=%b%b expected all 0",
                              busy, ram_we, ram_addr, ram_wdata, i_ack, d_ack);
        end
        reset = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h00A; d_wdata = 32'h12345678;
        tick();
        tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL rst_access_we: got %b expected 1", ram_we); end
        reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
        tick();
        tests++; if ({busy, d_ack} !== 2'b00) begin fails++; $display("FAIL rst_access_state: got busy/ack %b expected 00", {busy, d_ack}); end
        reset = 1'b0;
        tick();
        tests++; if (d_ack !== 1'b0) begin fails++; $display("FAIL rst_access_no_late_ack: got %b expected 0", d_ack); end
        d_op(1'b0, 10'h00A, 32'h0, rd, lat, saw_i);
        tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL rst_store_committed: got %h expected 12345678", rd); end
    endtask

    task automatic test_withdraw();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        tick();
        d_req = 1'b0;
        tick();
        tests++; if (d_ack !== 1'b1) begin fails++; $display("FAIL withdraw_ack: got %b expected 1", d_ack); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [0:15];
        logic [31:0] rd;
        int          lat;
        logic        saw_i;
        logic        i_act = 1'b0;
        logic        d_act = 1'b0;
        logic        i_seen = 1'b0;
        logic        prev_busy = 1'b0;
        int          i_wait = 0;
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            d_op(1'b1, 10'h020 + 10'(k), model[k], rd, lat, saw_i);
            tests++; if (lat !== 2) begin fails++; $display("FAIL preload_latency[%0d]: got %0d expected 2", k, lat); end
        end
        for (int cyc = 0; cyc < 900; cyc++) begin
            tick();
            if (i_seen) i_wait++;
            tests++; if (i_ack && d_ack) begin fails++; $display("FAIL rnd_onehot cyc %0d: got acks 11 expected at most one", cyc); end
            tests++; if (ram_we && !(busy && !prev_busy)) begin
                fails++; $display("FAIL rnd_we_outside_access cyc %0d: got we=1 busy=%b prev=%b", cyc, busy, prev_busy);
            end
            if (d_ack) begin
                tests++;
                if (!d_act) begin
                    fails++; $display("FAIL rnd_d_ack_unowned cyc %0d: got ack expected none", cyc);
                end else if (d_we) begin
                    model[d_addr[3:0]] = d_wdata;
                end else if (d_rdata !== model[d_addr[3:0]]) begin
                    fails++; $display("FAIL rnd_d_data addr %h: got %h expected %h", d_addr, d_rdata, model[d_addr[3:0]]);
                end
                d_act = 1'b0; d_req = 1'b0;
            end
            if (i_ack) begin
                tests++;
                if (!i_act || i_rdata !== model[i_addr[3:0]]) begin
                    fails++; $display("FAIL rnd_i_data addr %h: got %h expected %h (req %b)", i_addr, i_rdata, model[i_addr[3:0]], i_act);
                end
                tests++; if (i_wait > (STARVE_LIMIT + 1) * 3) begin
                    fails++; $display("FAIL rnd_i_wait: got %0d cycles expected <= %0d", i_wait, (STARVE_LIMIT + 1) * 3);
                end
                i_act = 1'b0; i_seen = 1'b0; i_req = 1'b0;
            end
            prev_busy = busy;
            if (cyc < 800) begin
                if (!d_act && $urandom_range(0, 3) != 0) begin
                    d_act = 1'b1; d_req = 1'b1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = 10'h020 + 10'($urandom_range(0, 15));
                    d_wdata = $urandom;
                end
                if (!i_act && $urandom_range(0, 3) != 0) begin
                    i_act = 1'b1; i_req = 1'b1;
                    i_addr = 10'h020 + 10'($urandom_range(0, 15));
                end
            end
            if (i_act && !i_seen && !busy) begin
                i_seen = 1'b1; i_wait = 0;
            end
        end
        tests++; if (i_act || d_act) begin
            fails++; $display("FAIL rnd_drain: got pending i=%b d=%b expected none", i_act, d_act);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_both_same_cycle();
        test_starvation();
        test_top_address();
        test_reset_mid();
        test_withdraw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
